regfile_scan_reader: RTL

Read-side companion to the 8 x 4-bit register file. It takes the file's eight parallel data buses and streams a contiguous, wrap-around range of registers out as {address, data} words over a valid/ready handshake. Downstream consumers (display, serial bridge, checker) use it to dump register contents without tapping all 32 data lines themselves.

---
 rtl/regfile_scan_reader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/regfile_scan_reader.sv
// regfile_scan_reader
// Streams a contiguous, wrap-around range of the 8 x 4-bit register file
// out as {RD_ADDR, RD_DATA} words over a valid/ready handshake.
//
// Optional feature macro: REGFILE_SCAN_SNAPSHOT_EN
//   defined   : all eight DATAx buses are captured on the START edge and
//               every word of the scan is read from that 32-bit snapshot.
//   undefined : no snapshot storage; each word is read live from DATAx at
//               the edge that loads it into RD_DATA.
//
// Handshake: a word transfers on a rising CLK edge where RD_VALID=1 and
// RD_READY=1. While RD_VALID=1 and no transfer happens, RD_DATA/RD_ADDR
// hold. RD_VALID never depends combinationally on RD_READY, and ABORT
// takes priority over a transfer on the same edge.
//
// DBG_STATE exposes the FSM state: 0=IDLE, 1=SEND, 2=FIN.

module regfile_scan_reader (
  input  logic       CLK,
  input  logic       CLRN,
  input  logic       START,
  input  logic       RA2,
  input  logic       RA1,
  input  logic       RA0,
  input  logic [2:0] LEN,
  input  logic       ABORT,
  input  logic [3:0] DATA0,
  input  logic [3:0] DATA1,
  input  logic [3:0] DATA2,
  input  logic [3:0] DATA3,
  input  logic [3:0] DATA4,
  input  logic [3:0] DATA5,
  input  logic [3:0] DATA6,
  input  logic [3:0] DATA7,
  input  logic       RD_READY,
  output logic       RD_VALID,
  output logic [3:0] RD_DATA,
  output logic [2:0] RD_ADDR,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_ptr;
  logic [2:0]  r_rem;

  logic [31:0] w_live;
  logic [31:0] w_scan_src;
  logic [2:0]  w_start_addr;
  logic [2:0]  w_next_ptr;
  logic [3:0]  w_first_word;
  logic [3:0]  w_next_word;
  logic        w_start_ok;
  logic        w_xfer;

  // Pick one 4-bit register out of a packed 8 x 4-bit bus.
  function automatic logic [3:0] pick_word(input logic [31:0] bus,
                                           input logic [2:0]  idx);
    return bus[{idx, 2'b00} +: 4];
  endfunction

  assign w_live       = {DATA7, DATA6, DATA5, DATA4, DATA3, DATA2, DATA1, DATA0};
  assign w_start_addr = {RA2, RA1, RA0};
  assign w_next_ptr   = r_ptr + 3'd1;
  assign w_start_ok   = (r_state == S_IDLE) && START;
  assign w_xfer       = RD_VALID && RD_READY;

`ifdef REGFILE_SCAN_SNAPSHOT_EN
  logic [31:0] r_snap;

  // Freeze the whole register file at the START edge.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_snap <= 32'd0;
    end else if (w_start_ok) begin
      r_snap <= w_live;
    end
  end

  assign w_scan_src = r_snap;
`else
  assign w_scan_src = w_live;
`endif

  // The first word is always taken live: at the START edge the snapshot is
  // being written with exactly these values, so both builds agree.
  assign w_first_word = pick_word(w_live, w_start_addr);
  assign w_next_word  = pick_word(w_scan_src, w_next_ptr);

  // Scan FSM with registered handshake and status outputs.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_state  <= S_IDLE;
      r_ptr    <= 3'd0;
      r_rem    <= 3'd0;
      RD_VALID <= 1'b0;
      RD_DATA  <= 4'd0;
      RD_ADDR  <= 3'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            r_ptr    <= w_start_addr;
            r_rem    <= LEN;
            RD_DATA  <= w_first_word;
            RD_ADDR  <= w_start_addr;
            RD_VALID <= 1'b1;
            BUSY     <= 1'b1;
            r_state  <= S_SEND;
          end
        end

        S_SEND: begin
          if (ABORT) begin
            // Cancel wins over a same-edge transfer; no DONE pulse.
            RD_VALID <= 1'b0;
            BUSY     <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_xfer) begin
            if (r_rem == 3'd0) begin
              RD_VALID <= 1'b0;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
              r_state  <= S_FIN;
            end else begin
              r_ptr   <= w_next_ptr;
              r_rem   <= r_rem - 3'd1;
              RD_DATA <= w_next_word;
              RD_ADDR <= w_next_ptr;
            end
          end
        end

        S_FIN: begin
          DONE    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          RD_VALID <= 1'b0;
          BUSY     <= 1'b0;
          DONE     <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign DBG_STATE = r_state;

endmodule
